// File: rtl/data_memory_responder.sv
// Data-memory responder: services load/store requests from the core against
// an internal word-organised RAM, with per-operation wait states, byte-lane
// steering, load extension and rejection of misaligned or illegal accesses.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for read_enable/write_enable; request fields latched here
// WAIT   | counting down the wait states of the accepted access
// DONE   | ready pulse; misaligned_error qualifies it; back to IDLE next
module data_memory_responder #(
  parameter int ADDR_WIDTH    = 12,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  data_format,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        misaligned_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

  state_t                r_state;
  logic [3:0]            r_count;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_fmt;
  logic                  r_rd;
  logic                  r_wr;

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic                  w_idle;
  logic                  w_req;
  logic [ADDR_WIDTH+1:0] w_addr;
  logic [31:0]           w_wdata;
  logic [2:0]            w_fmt;
  logic                  w_rd;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [31:0]           w_merge;
  logic                  w_err;
  logic [3:0]            w_lat;
  logic                  w_finish;
  logic                  w_commit;
  logic                  w_unused_addr;

  // In IDLE the access may complete on the very edge it is sampled (zero
  // latency), so the live inputs are used there; otherwise the latched copy.
  assign w_idle  = (r_state == S_IDLE);
  assign w_req   = read_enable | write_enable;
  assign w_addr  = w_idle ? address[ADDR_WIDTH+1:0] : r_addr;
  assign w_wdata = w_idle ? write_data  : r_wdata;
  assign w_fmt   = w_idle ? data_format : r_fmt;
  assign w_rd    = w_idle ? read_enable  : r_rd;
  assign w_wr    = w_idle ? write_enable : r_wr;

  // Upper address bits alias onto the RAM and are intentionally dropped.
  assign w_unused_addr = ^address[31:ADDR_WIDTH+2];

  assign w_idx  = w_addr[ADDR_WIDTH+1:2];
  assign w_lane = w_addr[1:0];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

  // A simultaneous read and write request uses the load latency.
  assign w_lat = (write_enable && !read_enable) ? WR_LAT : RD_LAT;

  assign w_finish = (w_idle && w_req && (w_lat == 4'd0)) ||
                    ((r_state == S_WAIT) && (r_count == 4'd1));
  assign w_commit = reset && w_finish && w_wr && !w_rd && !w_err;

  // Rejection: both enables, misaligned halves/words, illegal formats.
  always_comb begin
    w_err = 1'b0;
    if (w_rd && w_wr) begin
      w_err = 1'b1;
    end else begin
      case (w_fmt)
        3'b000:  w_err = 1'b0;
        3'b001:  w_err = w_lane[0];
        3'b010:  w_err = |w_lane;
        3'b100:  w_err = w_wr;
        3'b101:  w_err = w_wr | w_lane[0];
        default: w_err = 1'b1;
      endcase
    end
  end

  // Load result: lane select plus sign or zero extension.
  always_comb begin
    w_load = 32'h0;
    case (w_fmt)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      3'b010:  w_load = w_word;
      default: w_load = 32'h0;
    endcase
  end

  // Store merge: only the addressed lanes change.
  always_comb begin
    w_merge = w_word;
    case (w_fmt)
      3'b000:  w_merge[{w_lane, 3'b000} +: 8] = w_wdata[7:0];
      3'b001:  w_merge[{w_lane[1], 4'b0000} +: 16] = w_wdata[15:0];
      3'b010:  w_merge = w_wdata;
      default: w_merge = w_word;
    endcase
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_commit) begin
      r_mem[w_idx] <= w_merge;
    end
  end

  // Sequencing FSM with registered completion outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_count          <= 4'd0;
      r_addr           <= '0;
      r_wdata          <= 32'h0;
      r_fmt            <= 3'b000;
      r_rd             <= 1'b0;
      r_wr             <= 1'b0;
      read_data        <= 32'h0;
      ready            <= 1'b0;
      misaligned_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= address[ADDR_WIDTH+1:0];
            r_wdata <= write_data;
            r_fmt   <= data_format;
            r_rd    <= read_enable;
            r_wr    <= write_enable;
            r_count <= w_lat;
            r_state <= (w_lat == 4'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          ready            <= 1'b0;
          misaligned_error <= 1'b0;
          r_state          <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_finish) begin
        ready            <= 1'b1;
        misaligned_error <= w_err;
        if (w_err) begin
          read_data <= 32'h0;
        end else if (w_rd) begin
          read_data <= w_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: the driver pushes the expected completion (data, error,
// cycle) for each request; monitors pop and compare whenever ready pulses.
module tb_data_memory_responder;

  logic        clk;
  logic        rst_n;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [31:0] addr_a, wd_a, addr_b, wd_b;
  logic [2:0]  fmt_a, fmt_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rdy_a, rdy_b, err_a, err_b;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;

  data_memory_responder #(.ADDR_WIDTH(12), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut (
    .clock(clk), .reset(rst_n), .read_enable(rd_a), .write_enable(wr_a),
    .address(addr_a), .write_data(wd_a), .data_format(fmt_a),
    .read_data(rdata_a), .ready(rdy_a), .misaligned_error(err_a));

  data_memory_responder #(.ADDR_WIDTH(12), .READ_LATENCY(0), .WRITE_LATENCY(1)) dut0 (
    .clock(clk), .reset(rst_n), .read_enable(rd_b), .write_enable(wr_b),
    .address(addr_b), .write_data(wd_b), .data_format(fmt_b),
    .read_data(rdata_b), .ready(rdy_b), .misaligned_error(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy_a) begin
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready_a: ready=1 at cycle %0d, required none", cyc);
        end else begin
          exp_t e;
          e = sb_a.pop_front();
          if (rdata_a !== e.data || err_a !== e.err || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL resp_a: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                     rdata_a, err_a, cyc, e.data, e.err, e.cyc);
          end
        end
      end else if (err_a) begin
        checks++;
        errors++;
        $display("FAIL err_without_ready_a: misaligned_error=1 with ready=0 at cycle %0d", cyc);
      end
    end
  end

  // Monitor for the zero-read-latency instance.
  always @(negedge clk) begin
    if (rst_n && rdy_b) begin
      checks++;
      if (sb_b.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready_b: ready=1 at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sb_b.pop_front();
        if (rdata_b !== e.data || err_b !== e.err || cyc != e.cyc) begin
          errors++;
          $display("FAIL resp_b: got data=%h err=%b cycle=%0d, required data=%h err=%b cycle=%0d",
                   rdata_b, err_b, cyc, e.data, e.err, e.cyc);
        end
      end
    end
  end

  // Issue one request, push its expectation, hold inputs until ready is seen.
  // lat < 0 leaves the completion cycle unchecked.
  task automatic acc(input bit b, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] f,
                     input logic [31:0] exp_d, input bit exp_e, input int lat);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    if (b) begin rd_b = rd; wr_b = wr; addr_b = a; wd_b = wd; fmt_b = f; end
    else   begin rd_a = rd; wr_a = wr; addr_a = a; wd_a = wd; fmt_a = f; end
    e.data = exp_d;
    e.err  = exp_e;
    e.cyc  = (lat < 0) ? -1 : cyc + lat + 1;
    if (b) sb_b.push_back(e); else sb_a.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (b ? rdy_b : rdy_a) got = 1'b1;
    end
    if (b) begin rd_b = 1'b0; wr_b = 1'b0; end
    else   begin rd_a = 1'b0; wr_a = 1'b0; end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ready for addr=%h within 40 cycles, required ready", a);
      if (b) void'(sb_b.pop_back()); else void'(sb_a.pop_back());
    end
  endtask

  task automatic sw_a(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    acc(1'b0, 1'b0, 1'b1, a, d, f, last_a, 1'b0, 1);
  endtask

  task automatic ld_a(input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp_d);
    acc(1'b0, 1'b1, 1'b0, a, 32'h0, f, exp_d, 1'b0, 2);
    last_a = exp_d;
  endtask

  task automatic bad_a(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] f, input int lat);
    acc(1'b0, rd, wr, a, 32'h5555AAAA, f, 32'h0, 1'b1, lat);
    last_a = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_a = 0; wr_a = 0; addr_a = 0; wd_a = 0; fmt_a = 0;
    rd_b = 0; wr_b = 0; addr_b = 0; wd_b = 0; fmt_b = 0;
    repeat (3) @(negedge clk);
    chk("reset_read_data_a", rdata_a, 32'h0);
    chk("reset_ready_a", {31'h0, rdy_a}, 32'h0);
    chk("reset_err_a", {31'h0, err_a}, 32'h0);
    chk("reset_read_data_b", rdata_b, 32'h0);
    chk("reset_ready_b", {31'h0, rdy_b}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Word store then load, latency 1 and 2.
    sw_a(32'h100, 32'hDEADBEEF, 3'b010);
    ld_a(32'h100, 3'b010, 32'hDEADBEEF);

    // Lane select and extension.
    sw_a(32'h20, 32'h80FF7F01, 3'b010);
    ld_a(32'h23, 3'b000, 32'hFFFFFF80);
    ld_a(32'h23, 3'b100, 32'h00000080);
    ld_a(32'h22, 3'b001, 32'hFFFF80FF);
    ld_a(32'h20, 3'b101, 32'h00007F01);
    ld_a(32'h21, 3'b000, 32'h0000007F);

    // Sub-word stores merge into the existing word.
    sw_a(32'h20, 32'h11223344, 3'b010);
    sw_a(32'h21, 32'hFFFFFFAA, 3'b000);
    ld_a(32'h20, 3'b010, 32'h1122AA44);
    sw_a(32'h22, 32'h1234BEEF, 3'b001);
    ld_a(32'h20, 3'b010, 32'hBEEFAA44);

    // Rejected accesses: no RAM effect, read_data cleared.
    bad_a(1'b1, 1'b0, 32'h102, 3'b010, 2);
    ld_a(32'h100, 3'b010, 32'hDEADBEEF);
    bad_a(1'b1, 1'b0, 32'h101, 3'b001, 2);
    bad_a(1'b1, 1'b0, 32'h100, 3'b011, 2);
    bad_a(1'b0, 1'b1, 32'h100, 3'b100, 1);
    bad_a(1'b0, 1'b1, 32'h102, 3'b010, 1);
    bad_a(1'b1, 1'b1, 32'h100, 3'b010, -1);
    ld_a(32'h100, 3'b010, 32'hDEADBEEF);

    // Reset during the wait of a store discards it.
    sw_a(32'h40, 32'h0, 3'b010);
    @(posedge clk); #1;
    wr_a = 1'b1; rd_a = 1'b0; addr_a = 32'h40; wd_a = 32'h12345678; fmt_a = 3'b010;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_read_data", rdata_a, 32'h0);
    chk("midreset_ready", {31'h0, rdy_a}, 32'h0);
    @(negedge clk); wr_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_ready_held", {31'h0, rdy_a}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    last_a = 32'h0;
    repeat (3) @(negedge clk);
    ld_a(32'h40, 3'b010, 32'h00000000);

    // Address aliasing above the RAM size.
    sw_a(32'h4008, 32'hCAFEF00D, 3'b010);
    ld_a(32'h0008, 3'b010, 32'hCAFEF00D);

    // Zero read latency instance.
    acc(1'b1, 1'b0, 1'b1, 32'h8, 32'h13579BDF, 3'b010, last_b, 1'b0, 1);
    acc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 32'h13579BDF, 1'b0, 0);
    last_b = 32'h13579BDF;
    acc(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 3'b000, 32'h00000057, 1'b0, 0);
    acc(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 3'b010, 32'h0, 1'b1, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_a_drained", sb_a.size(), 32'h0);
    chk("scoreboard_b_drained", sb_b.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
